multicycle_control: RTL

- Multi-cycle MIPS main control FSM that sequences the shared datapath: register file, instruction/data memory, ALU, PC and instruction register.
- One instruction is in flight at a time.
- Generates every datapath strobe and mux select from the current state and the opcode captured in the IR.
- Waits on a memory ready handshake during fetch, load and store.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_control_decode.sv | 70 +++++++
 rtl/multicycle_control.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode and datapath-select encodings for the multicycle MIPS control FSM
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// rtl/multicycle_control_decode.sv - combinational state-to-strobe decode for the multicycle MIPS control FSM
module multicycle_control_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   enable_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: ctrl_o.reg_write = 1'b1;
      default: ;
    endcase
    // Reset state is FETCH, which would otherwise request a memory read.
    if (!enable_i) ctrl_o = '0;
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS main control FSM; MULTICYCLE_CONTROL_PERF_EN adds retire/stall counters
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W           = 6,
  parameter bit ADDI_EN_DEFAULT = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
`ifdef MULTICYCLE_CONTROL_PERF_EN
  output logic [31:0]      instr_retired,
  output logic [31:0]      stall_cycles,
`endif
  output logic             illegal_op
);

  state_e state_q, state_d;
  logic   is_lw_q;
  logic   illegal;
  ctrl_t  ctrl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      is_lw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Remember lw vs sw so MEM_ADDR never looks at the opcode bus again.
      if (state_q == S_DECODE) is_lw_q <= (opcode == OPC_W'(OP_LW));
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OPC_W'(OP_LW) || opcode == OPC_W'(OP_SW)) state_d = S_MEM_ADDR;
        else if (opcode == OPC_W'(OP_R))                         state_d = S_R_EXEC;
        else if (opcode == OPC_W'(OP_BEQ))                       state_d = S_BRANCH;
        else if (opcode == OPC_W'(OP_J))                         state_d = S_JUMP;
        else if (ADDI_EN_DEFAULT && opcode == OPC_W'(OP_ADDI))   state_d = S_ADDI_EXEC;
        else begin
          state_d = S_FETCH;
          illegal = 1'b1;
        end
      end
      S_MEM_ADDR:  state_d = is_lw_q ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  multicycle_control_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .enable_i    (reset_n),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = illegal & reset_n;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] retired_q, stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      // The illegal path leaves DECODE for FETCH and retires nothing.
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_DECODE)
        retired_q <= retired_q + 32'd1;
      if (!mem_ready && (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign instr_retired = retired_q;
  assign stall_cycles  = stall_q;
`endif

endmodule
